// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier with load/multiply/done handshake.
// One partial-product iteration per clock; the product is held until the next completion.
module shift_add_mult #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Ld_in,
   input  logic               multiply,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic [2*WIDTH-1:0] product,
   output logic               done,
   output logic               busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] q;
   logic [WIDTH:0]   acc;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   sum;

   // acc keeps one spare bit so the add carry survives the shift
   assign sum = q[0] ? acc + {1'b0, m} : acc;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         m       <= '0;
         q       <= '0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (multiply) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  acc   <= '0;
                  cnt   <= '0;
               end else if (Ld_in) begin
                  m   <= a_in;
                  q   <= b_in;
                  acc <= '0;
                  cnt <= '0;
               end
            end
            RUN: begin
               if (!multiply) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  {acc, q} <= {1'b0, sum, q[WIDTH-1:1]};
                  cnt      <= cnt + 1'b1;
                  if (cnt == CW'(WIDTH - 1)) begin
                     product <= {sum, q[WIDTH-1:1]};
                     state   <= DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (!multiply) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
